// File: rtl/led_event_scheduler.sv
// Round-robin time-sharing of one activity LED across NCH latched event channels.
// Optional feature macro LED_SCHED_BLINK_EN: LED blinks every BLINK_HALF cycles while a channel is shown.
module led_event_scheduler #(
  parameter int unsigned NCH          = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HOLD = 2500000,
  parameter int unsigned GAP          = 250000,
  parameter int unsigned BLINK_HALF   = 125000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NCH-1:0]   i_ev,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_hold,
  output logic             o_led,
  output logic [NCH-1:0]   o_led_sel,
  output logic [NCH-1:0]   o_pend,
  output logic             o_busy
);

  localparam int unsigned      PTR_W    = $clog2(NCH);
  localparam logic [CNT_W-1:0] HOLD_RST = CNT_W'(DEFAULT_HOLD);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] w_hold_eff;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   w_pend_nxt;
  logic             r_led;
  logic             w_led_nxt;
  logic [NCH-1:0]   r_led_sel;
  logic [NCH-1:0]   w_sel_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  logic [NCH-1:0]   w_req;
  logic             w_any;
  logic [PTR_W-1:0] w_grant;
  logic [NCH-1:0]   w_grant_oh;
  logic [PTR_W-1:0] w_ptr_adv;
  logic             w_retrig;
  logic             w_load;

`ifdef LED_SCHED_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LEN = CNT_W'(BLINK_HALF);
  logic [CNT_W-1:0] r_blink;
  logic [CNT_W-1:0] w_blink_nxt;
`else
  logic w_unused_blink;
  assign w_unused_blink = (BLINK_HALF == 0);
`endif

  // First requesting channel at or above ptr, wrapping around.
  function automatic logic [PTR_W-1:0] f_pick(input logic [NCH-1:0] req,
                                              input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] grant;
    logic             found;
    int unsigned      idx;
    grant = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[PTR_W'(idx)]) begin
        found = 1'b1;
        grant = PTR_W'(idx);
      end
    end
    return grant;
  endfunction

  assign w_req      = r_pend | i_ev;
  assign w_any      = |w_req;
  assign w_grant    = f_pick(w_req, r_ptr);
  assign w_grant_oh = NCH'(1) << w_grant;
  assign w_ptr_adv  = (w_grant == PTR_LAST) ? '0 : w_grant + PTR_W'(1);
  assign w_hold_eff = (r_hold == '0) ? ONE : r_hold;
  assign w_retrig   = |(i_ev & r_led_sel);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_pend_nxt  = r_pend;
    w_led_nxt   = r_led;
    w_sel_nxt   = r_led_sel;
    w_load      = 1'b0;
`ifdef LED_SCHED_BLINK_EN
    w_blink_nxt = r_blink;
`endif
    case (r_state)
      S_IDLE: begin
        w_led_nxt = 1'b0;
        w_sel_nxt = '0;
        w_load    = w_any;
      end
      S_SHOW: begin
        w_pend_nxt = r_pend | (i_ev & ~r_led_sel);
        if (w_retrig) begin
          w_cnt_nxt = w_hold_eff;
          w_led_nxt = 1'b1;
`ifdef LED_SCHED_BLINK_EN
          w_blink_nxt = BLINK_LEN;
`endif
        end else if (r_cnt <= ONE) begin
          w_led_nxt   = 1'b0;
          w_sel_nxt   = '0;
          w_cnt_nxt   = GAP_LEN;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
`ifdef LED_SCHED_BLINK_EN
          if (r_blink <= ONE) begin
            w_led_nxt   = ~r_led;
            w_blink_nxt = BLINK_LEN;
          end else begin
            w_blink_nxt = r_blink - ONE;
          end
`endif
        end
      end
      S_GAP: begin
        if (r_cnt <= ONE) begin
          w_load      = w_any;
          w_state_nxt = S_IDLE;
        end else begin
          w_pend_nxt = r_pend | i_ev;
          w_cnt_nxt  = r_cnt - ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Shared grant/load path for IDLE and end of GAP.
    if (w_load) begin
      w_state_nxt = S_SHOW;
      w_cnt_nxt   = w_hold_eff;
      w_led_nxt   = 1'b1;
      w_sel_nxt   = w_grant_oh;
      w_pend_nxt  = w_req & ~w_grant_oh;
      w_ptr_nxt   = w_ptr_adv;
`ifdef LED_SCHED_BLINK_EN
      w_blink_nxt = BLINK_LEN;
`endif
    end
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_hold    <= HOLD_RST;
      r_ptr     <= '0;
      r_pend    <= '0;
      r_led     <= 1'b0;
      r_led_sel <= '0;
      r_busy    <= 1'b0;
`ifdef LED_SCHED_BLINK_EN
      r_blink   <= '0;
`endif
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_pend    <= w_pend_nxt;
      r_led     <= w_led_nxt;
      r_led_sel <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
`ifdef LED_SCHED_BLINK_EN
      r_blink   <= w_blink_nxt;
`endif
      // A running count keeps its value; the new hold applies at the next load.
      if (i_cfg_we) r_hold <= i_cfg_hold;
    end
  end

  assign o_led     = r_led;
  assign o_led_sel = r_led_sel;
  assign o_pend    = r_pend;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_led_event_scheduler.sv
// Self-checking bench for led_event_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count reference model.
module tb_led_event_scheduler;

  localparam int unsigned NCH          = 4;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned DEFAULT_HOLD = 10;
  localparam int unsigned GAP          = 3;
  localparam int unsigned BLINK_HALF   = 2;

  logic             clk;
  logic             i_reset;
  logic [NCH-1:0]   i_ev;
  logic             i_cfg_we;
  logic [CNT_W-1:0] i_cfg_hold;
  logic             o_led;
  logic [NCH-1:0]   o_led_sel;
  logic [NCH-1:0]   o_pend;
  logic             o_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: remaining lit / dark cycle counts and a pending bitmap.
  int             m_hold;
  int             m_ch;
  int             m_show_left;
  int             m_gap_left;
  int             m_ptr;
  int             m_since;
  logic [NCH-1:0] m_pend;

  led_event_scheduler #(
    .NCH(NCH), .CNT_W(CNT_W), .DEFAULT_HOLD(DEFAULT_HOLD), .GAP(GAP), .BLINK_HALF(BLINK_HALF)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ev(i_ev), .i_cfg_we(i_cfg_we), .i_cfg_hold(i_cfg_hold),
    .o_led(o_led), .o_led_sel(o_led_sel), .o_pend(o_pend), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic try_start(input logic [NCH-1:0] ev, input int he);
    logic [NCH-1:0] req;
    int c;
    req = m_pend | ev;
    for (int i = 0; i < NCH; i++) begin
      c = (m_ptr + i) % NCH;
      if (req[c]) begin
        m_pend      = req;
        m_pend[c]   = 1'b0;
        m_ptr       = (c + 1) % NCH;
        m_ch        = c;
        m_show_left = he;
        m_since     = 0;
        return;
      end
    end
  endtask

  task automatic model_step(input logic [NCH-1:0] ev, input logic we, input int hin, input logic rst);
    int he;
    if (rst) begin
      m_hold = DEFAULT_HOLD; m_ch = -1; m_show_left = 0; m_gap_left = 0;
      m_ptr = 0; m_since = 0; m_pend = '0;
      return;
    end
    he = (m_hold == 0) ? 1 : m_hold;
    if (m_show_left > 0) begin
      for (int c = 0; c < NCH; c++)
        if (c != m_ch && ev[c]) m_pend[c] = 1'b1;
      if (ev[m_ch]) begin
        m_show_left = he;
        m_since     = 0;
      end else begin
        m_show_left--;
        m_since++;
      end
      if (m_show_left == 0) begin
        m_ch       = -1;
        m_gap_left = GAP;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) try_start(ev, he);
      else m_pend = m_pend | ev;
    end else begin
      try_start(ev, he);
    end
    if (we) m_hold = hin;
  endtask

  task automatic check_model();
    logic           e_led;
    logic [NCH-1:0] e_sel;
    e_led = (m_show_left > 0);
`ifdef LED_SCHED_BLINK_EN
    if (((m_since / BLINK_HALF) % 2) != 0) e_led = 1'b0;
`endif
    e_sel = '0;
    if (m_ch >= 0) e_sel[m_ch] = 1'b1;
    chk("model_led",  32'(o_led),     32'(e_led));
    chk("model_sel",  32'(o_led_sel), 32'(e_sel));
    chk("model_pend", 32'(o_pend),    32'(m_pend));
    chk("model_busy", 32'(o_busy),    32'((m_show_left > 0) || (m_gap_left > 0)));
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after it.
  task automatic step(input logic [NCH-1:0] ev, input logic we, input int hin, input logic rst);
    i_ev = ev; i_cfg_we = we; i_cfg_hold = 32'(hin); i_reset = rst;
    @(posedge clk);
    model_step(ev, we, hin, rst);
    #1;
    i_ev = '0; i_cfg_we = 1'b0; i_reset = 1'b0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 0, 1'b0);
  endtask

  // Count consecutive cycles with a channel selected, starting at the current sample.
  task automatic measure_show(output int n);
    n = 0;
    while (o_led_sel != '0 && n < 100) begin
      n++;
      step('0, 1'b0, 0, 1'b0);
    end
  endtask

`ifdef LED_SCHED_BLINK_EN
  logic blink_pat [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`endif

  initial begin
    int n;
    int total;
    logic [NCH-1:0] rev;
    i_reset = 1'b1; i_ev = '0; i_cfg_we = 1'b0; i_cfg_hold = '0;

    // Reset values
    step('0, 1'b0, 0, 1'b1);
    chk("rst_led", 32'(o_led), 32'd0);
    chk("rst_sel", 32'(o_led_sel), 32'd0);
    chk("rst_pend", 32'(o_pend), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);

    // Single event on ch2
    idle(3);
    step(4'b0100, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("single_sel", 32'(o_led_sel), 32'h4);
`ifndef LED_SCHED_BLINK_EN
      chk("single_led", 32'(o_led), 32'd1);
`endif
      chk("single_pend", 32'(o_pend), 32'd0);
      step('0, 1'b0, 0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("single_gap_led", 32'(o_led), 32'd0);
      chk("single_gap_busy", 32'(o_busy), 32'd1);
      step('0, 1'b0, 0, 1'b0);
    end
    chk("single_done_busy", 32'(o_busy), 32'd0);

    // Simultaneous ch0 and ch3 from reset
    step('0, 1'b0, 0, 1'b1);
    step(4'b1001, 1'b0, 0, 1'b0);
    chk("simul_first_sel", 32'(o_led_sel), 32'h1);
    for (int i = 0; i < 13; i++) begin
      chk("simul_pend", 32'(o_pend), 32'h8);
      step('0, 1'b0, 0, 1'b0);
    end
    chk("simul_second_sel", 32'(o_led_sel), 32'h8);
    measure_show(n);
    chk("simul_second_len", 32'(n), 32'd10);
    idle(4);
    step(4'b0011, 1'b0, 0, 1'b0);
    chk("simul_ptr_wrap_sel", 32'(o_led_sel), 32'h1);

    // Retrigger on ch1
    step('0, 1'b0, 0, 1'b1);
    step(4'b0010, 1'b0, 0, 1'b0);
    idle(3);
    step(4'b0010, 1'b0, 0, 1'b0);
    chk("retrig_pend", 32'(o_pend), 32'd0);
    measure_show(n);
    chk("retrig_len", 32'(n + 4), 32'd14);

    // Config: hold 0 acts as 1, then a hold change mid-show
    step('0, 1'b0, 0, 1'b1);
    step('0, 1'b1, 0, 1'b0);
    idle(2);
    step(4'b0001, 1'b0, 0, 1'b0);
    measure_show(n);
    chk("cfg_zero_len", 32'(n), 32'd1);
    idle(3);
    step('0, 1'b1, 10, 1'b0);
    step(4'b0001, 1'b0, 0, 1'b0);
    step('0, 1'b0, 0, 1'b0);
    step('0, 1'b1, 20, 1'b0);
    measure_show(n);
    total = n + 2;
    chk("cfg_running_len", 32'(total), 32'd10);
    idle(3);
    step(4'b0001, 1'b0, 0, 1'b0);
    measure_show(n);
    chk("cfg_new_len", 32'(n), 32'd20);

    // Reset mid-show with pending channels; events in the reset cycle are dropped
    step('0, 1'b0, 0, 1'b1);
    step(4'b0001, 1'b0, 0, 1'b0);
    step(4'b0110, 1'b0, 0, 1'b0);
    chk("midrst_pend_before", 32'(o_pend), 32'h6);
    step(4'b0100, 1'b0, 0, 1'b1);
    chk("midrst_led", 32'(o_led), 32'd0);
    chk("midrst_sel", 32'(o_led_sel), 32'd0);
    chk("midrst_pend", 32'(o_pend), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    step(4'b1000, 1'b0, 0, 1'b0);
    chk("midrst_after_led", 32'(o_led), 32'd1);
    chk("midrst_after_sel", 32'(o_led_sel), 32'h8);

`ifdef LED_SCHED_BLINK_EN
    // Blink pattern on a single show
    step('0, 1'b0, 0, 1'b1);
    step(4'b0001, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("blink_led", 32'(o_led), 32'(blink_pat[i]));
      chk("blink_sel", 32'(o_led_sel), 32'h1);
      step('0, 1'b0, 0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("blink_gap_led", 32'(o_led), 32'd0);
      step('0, 1'b0, 0, 1'b0);
    end
`endif

    // Randomized traffic against the model
    step('0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) rev[c] = ($urandom_range(0, 11) == 0);
      step(rev, ($urandom_range(0, 19) == 0), int'($urandom_range(0, 6)),
           ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_event_scheduler.md
# led_event_scheduler

Time-shares one front-panel activity LED among NCH pulse channels of the timetag front end. Each channel's event strobe is latched as pending. A round-robin scheduler then shows one channel at a time: the LED is held lit for a programmable number of cycles, followed by a fixed dark gap. A one-hot select output tells the panel logic which channel is being displayed. The block sits between the channel discriminator outputs and the board LED pins and replaces per-channel free-running LED stretchers.

## Interface
- NCH, 4, number of event channels (2..16)
- CNT_W, 32, width of hold/gap counter and config word
- DEFAULT_HOLD, 2500000, hold length after reset, in clk cycles
- GAP, 250000, dark cycles between consecutive shows (≥1)
- BLINK_HALF, 125000, blink half-period in cycles (used only with blink macro)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ev  in  NCH  event strobes, level-sampled every cycle; any high cycle is one event
- cfg_we  in  1  load cfg_hold into hold register this cycle
- cfg_hold  in  CNT_W  new hold length; 0 is treated as 1
- led  out  1  LED drive
- led_sel  out  NCH  one-hot channel being shown; 0 when none
- pend  out  NCH  pending flags (registered)
- busy  out  1  high in SHOW or GAP

## Operation
- States: IDLE, SHOW, GAP.
- Request vector req = pend | ev.
- **IDLE**
  - If req≠0, grant the first set bit at or above ptr, wrapping.
  - Load cnt=hold_eff, led=1, led_sel=onehot(grant), clear pend[grant] (ev[grant] that cycle does not re-set it).
  - Set ptr=grant+1 mod NCH; go SHOW.
  - Else all outputs 0.
- **SHOW**
  - ev on the shown channel retriggers: cnt reloads to hold_eff; pend unaffected.
  - ev on other channels sets their pend.
  - Otherwise cnt decrements. When cnt==1 and there is no retrigger: led=0, led_sel=0, cnt=GAP; go GAP.
- **GAP**
  - ev sets pend; cnt decrements.
  - When cnt==1, apply the IDLE grant logic in the same cycle, going to SHOW if req≠0, else IDLE.
- hold register: reset to DEFAULT_HOLD; cfg_we writes it any cycle.
  - The new value applies only at the next load or retrigger; a running cnt is never modified.
  - hold_eff = (hold==0) ? 1 : hold.
- Multiple events on one channel while pending collapse to a single show; no counting.
- Counter arithmetic is unsigned CNT_W; cnt never decrements below 1 in any state.

## Timing
- Reset values: led=0, led_sel=0, pend=0, busy=0, state=IDLE, ptr=0, cnt=0, hold=DEFAULT_HOLD.
- Reset asserted mid-show: all of the above apply on the next edge; events in the reset cycle are discarded.
- Latency: ev high in cycle k with block IDLE → led=1 from cycle k+1.
- A show keeps led high for exactly hold_eff cycles after the last load or retrigger.
- A GAP keeps led low for exactly GAP cycles.
- Back-to-back pending channels: the next show starts on the first cycle after the gap, with no IDLE cycle in between.
- pend bits are visible one cycle after the ev cycle that set them.
- cfg_we and a load in the same cycle: the load uses the old hold value.

## Configuration
- LED_SCHED_BLINK_EN defined: during SHOW, led toggles every BLINK_HALF cycles, starting high at load; it is reset to high on retrigger. led_sel, cnt and show length are unchanged. led is forced low in GAP.
- Not defined: led is steady high for the whole SHOW; no blink logic is synthesized.

## Test plan
Parameters for all scenarios: NCH=4, DEFAULT_HOLD=10, GAP=3, BLINK_HALF=2.
- Single event, from reset: ev[2] high in cycle 5 only → led=1 and led_sel=0100 in cycles 6–15; led=0 in cycles 16–18; busy=0 from cycle 19; pend stays 0.
- Simultaneous events, from reset (ptr=0): ev[0] and ev[3] high in cycle 5 → ch0 shown in cycles 6–15, pend=1000 in cycles 6–18, ch3 shown in cycles 19–28 with led_sel=1000, ptr=0 afterwards.
- Retrigger: ev[1] at cycle 5, then ev[1] again at cycle 9 → led high in cycles 6–19 continuously, pend[1]=0 throughout.
- Config write: cfg_we with cfg_hold=0 in cycle 2, then ev[0] at cycle 5 → led high in cycle 6 only. A later cfg_hold=20 written in cycle 8 of a running 10-cycle show → that show still ends after 10 cycles; the next show lasts 20 cycles.
- Reset mid-operation: show running plus pend=0110, reset high in cycle 8 → cycle 9 has led=0, led_sel=0, pend=0, busy=0. ev[3] in cycle 10 → led high from cycle 11.
- Blink, with LED_SCHED_BLINK_EN defined: single ev[0] at cycle 5 → led pattern 1,1,0,0,1,1,0,0,1,1 over cycles 6–15, low through the gap, led_sel=0001 for all of cycles 6–15.
